// File: rtl/siso_shift_ctrl_if.sv
// Parallel-in / serial-out frame bus between a word producer, the frame
// controller and the serial line. The master side is the producer plus line
// stall source; the slave side is the controller.
interface siso_shift_ctrl_if #(
   parameter int unsigned WIDTH = 4
) ();

   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             shift_en;
   logic             s_out;
   logic             s_frame;
   logic             done;
   logic             busy;
   logic [7:0]       frame_cnt;

   modport master (
      output in_data,
      output in_valid,
      output shift_en,
      input  in_ready,
      input  s_out,
      input  s_frame,
      input  done,
      input  busy,
      input  frame_cnt
   );

   modport slave (
      input  in_data,
      input  in_valid,
      input  shift_en,
      output in_ready,
      output s_out,
      output s_frame,
      output done,
      output busy,
      output frame_cnt
   );

endinterface

// File: rtl/siso_shift_ctrl.sv
// Frame controller for a serial-out shift register. Takes a parallel word over
// valid/ready, emits it one bit per enabled cycle, pulses done after the last
// bit, then holds an idle gap before accepting the next word.
module siso_shift_ctrl #(
   parameter int unsigned WIDTH      = 4,
   parameter int unsigned GAP_CYCLES = 1,
   parameter bit          LSB_FIRST  = 1'b0
) (
   input logic             clk,
   input logic             rst_n,
   siso_shift_ctrl_if.slave bus_io
);

   localparam int unsigned BcW = $clog2(WIDTH);
   // Gap counter only needs to reach GAP_CYCLES-1; keep at least one bit.
   localparam int unsigned GcW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [BcW-1:0] BitLast = BcW'(WIDTH - 1);
   localparam logic [GcW-1:0] GapLast = GcW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StShift = 2'd1;
   localparam logic [1:0] StGap   = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [BcW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [GcW-1:0]   gap_cnt_q, gap_cnt_d;
   logic             in_ready_q, in_ready_d;
   logic             done_q, done_d;
   logic [7:0]       frame_cnt_q, frame_cnt_d;

   logic             accept;
   logic [WIDTH-1:0] shreg_shifted;

   assign accept = (state_q == StIdle) && in_ready_q && bus_io.in_valid;

   // Move the register one place toward the output end, zero-filling behind.
   always_comb begin
      shreg_shifted = '0;
      if (LSB_FIRST) begin
         shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
      end else begin
         shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
      end
   end

   // Next-state logic for the frame sequencer.
   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      bit_cnt_d   = bit_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      in_ready_d  = in_ready_q;
      done_d      = 1'b0;
      frame_cnt_d = frame_cnt_q;

      case (state_q)
         StIdle: begin
            // ready comes up one edge after reset and stays up until a word lands
            in_ready_d = 1'b1;
            if (accept) begin
               shreg_d    = bus_io.in_data;
               bit_cnt_d  = '0;
               in_ready_d = 1'b0;
               state_d    = StShift;
            end
         end

         StShift: begin
            in_ready_d = 1'b0;
            if (bus_io.shift_en) begin
               if (bit_cnt_q == BitLast) begin
                  done_d      = 1'b1;
                  frame_cnt_d = frame_cnt_q + 8'd1;
                  shreg_d     = '0;
                  bit_cnt_d   = '0;
                  if (GAP_CYCLES == 0) begin
                     state_d    = StIdle;
                     in_ready_d = 1'b1;
                  end else begin
                     state_d   = StGap;
                     gap_cnt_d = '0;
                  end
               end else begin
                  shreg_d   = shreg_shifted;
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end

         StGap: begin
            // shift_en is deliberately ignored; the gap is a fixed edge count
            in_ready_d = 1'b0;
            if (gap_cnt_q == GapLast) begin
               state_d    = StIdle;
               in_ready_d = 1'b1;
               gap_cnt_d  = '0;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end

         default: begin
            state_d    = StIdle;
            in_ready_d = 1'b0;
         end
      endcase
   end

   // State registers; reset aborts any frame in flight without a done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         shreg_q     <= '0;
         bit_cnt_q   <= '0;
         gap_cnt_q   <= '0;
         in_ready_q  <= 1'b0;
         done_q      <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         bit_cnt_q   <= bit_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         in_ready_q  <= in_ready_d;
         done_q      <= done_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   // Serial outputs come straight from the state and the register's output end.
   always_comb begin
      bus_io.s_frame = (state_q == StShift);
      bus_io.s_out   = 1'b0;
      if (state_q == StShift) begin
         bus_io.s_out = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
      end
   end

   assign bus_io.in_ready  = in_ready_q;
   assign bus_io.done      = done_q;
   assign bus_io.busy      = (state_q != StIdle);
   assign bus_io.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// Bench for siso_shift_ctrl: an MSB-first and an LSB-first instance share one
// stimulus stream. A frame-level model predicts every output per cycle, and a
// word scoreboard checks that each accepted word is serialised intact.
module tb_siso_shift_ctrl;

   localparam int unsigned W   = 4;
   localparam int unsigned GAP = 1;

   logic         clk      = 1'b0;
   logic         rst_n    = 1'b0;
   logic         in_valid = 1'b0;
   logic [W-1:0] in_data  = '0;
   logic         shift_en = 1'b0;

   always #5 clk = ~clk;

   siso_shift_ctrl_if #(.WIDTH(W)) bus_m ();
   siso_shift_ctrl_if #(.WIDTH(W)) bus_l ();

   assign bus_m.in_valid = in_valid;
   assign bus_m.in_data  = in_data;
   assign bus_m.shift_en = shift_en;
   assign bus_l.in_valid = in_valid;
   assign bus_l.in_data  = in_data;
   assign bus_l.shift_en = shift_en;

   siso_shift_ctrl #(.WIDTH(W), .GAP_CYCLES(GAP), .LSB_FIRST(1'b0)) dut_m (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (bus_m.slave)
   );

   siso_shift_ctrl #(.WIDTH(W), .GAP_CYCLES(GAP), .LSB_FIRST(1'b1)) dut_l (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (bus_l.slave)
   );

   int errors = 0;
   int checks = 0;

   // Frame-level model: bits left in the current frame, gap edges left.
   int           m_left  = 0;
   int           m_gap   = 0;
   bit           m_ready = 1'b0;
   bit           m_done  = 1'b0;
   int           m_cnt   = 0;
   logic [W-1:0] m_word  = '0;

   logic [W-1:0] exp_m[$];
   logic [W-1:0] exp_l[$];
   logic [W-1:0] col_m = '0;
   logic [W-1:0] col_l = '0;
   int           nb_m  = 0;
   int           nb_l  = 0;

   int done_cnt    = 0;  // since last reset
   int done_total  = 0;
   int frame_cyc_m = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_left  = 0;
      m_gap   = 0;
      m_ready = 1'b0;
      m_done  = 1'b0;
      m_cnt   = 0;
      exp_m.delete();
      exp_l.delete();
   endtask

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_step();
      if (!rst_n) begin
         model_reset();
      end else begin
         m_done = 1'b0;
         if (m_left > 0) begin
            if (shift_en) begin
               m_left--;
               if (m_left == 0) begin
                  m_done = 1'b1;
                  m_cnt  = (m_cnt + 1) % 256;
                  if (GAP == 0) m_ready = 1'b1;
                  else m_gap = GAP;
               end
            end
         end else if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0) m_ready = 1'b1;
         end else if (m_ready && in_valid) begin
            m_word  = in_data;
            m_left  = W;
            m_ready = 1'b0;
            exp_m.push_back(in_data);
            exp_l.push_back(in_data);
         end else begin
            m_ready = 1'b1;
         end
      end
   endtask

   function automatic logic exp_bit(input bit lsb);
      int idx;
      if (m_left == 0) return 1'b0;
      idx = lsb ? (W - m_left) : (m_left - 1);
      return m_word[idx];
   endfunction

   // Monitor: cycle-level comparison plus word reassembly for the scoreboard.
   always @(negedge clk) begin
      check("in_ready_m", bus_m.in_ready, m_ready);
      check("in_ready_l", bus_l.in_ready, m_ready);
      check("s_frame_m", bus_m.s_frame, m_left > 0);
      check("s_frame_l", bus_l.s_frame, m_left > 0);
      check("s_out_m", bus_m.s_out, exp_bit(1'b0));
      check("s_out_l", bus_l.s_out, exp_bit(1'b1));
      check("done_m", bus_m.done, m_done);
      check("done_l", bus_l.done, m_done);
      check("busy_m", bus_m.busy, (m_left > 0) || (m_gap > 0));
      check("frame_cnt_m", bus_m.frame_cnt, m_cnt);
      check("frame_cnt_l", bus_l.frame_cnt, m_cnt);
      if (bus_m.s_frame) frame_cyc_m++;
      if (bus_m.done) done_total++;
      if (!rst_n) begin
         nb_m     = 0;
         nb_l     = 0;
         done_cnt = 0;
      end else begin
         if (bus_m.done) done_cnt++;
         if (bus_m.s_frame && shift_en) begin
            col_m = {col_m[W-2:0], bus_m.s_out};
            nb_m++;
            if (nb_m == W) begin
               nb_m = 0;
               if (exp_m.size() == 0) check("word_m_unexpected", 1, 0);
               else check("word_m", col_m, exp_m.pop_front());
            end
         end
         if (bus_l.s_frame && shift_en) begin
            col_l[nb_l] = bus_l.s_out;
            nb_l++;
            if (nb_l == W) begin
               nb_l = 0;
               if (exp_l.size() == 0) check("word_l_unexpected", 1, 0);
               else check("word_l", col_l, exp_l.pop_front());
            end
         end
      end
   end

   task automatic step(input bit v, input logic [W-1:0] d, input bit s);
      in_valid = v;
      in_data  = d;
      shift_en = s;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      model_reset();
      repeat (n) step(1'b0, '0, 1'b0);
      rst_n = 1'b1;
   endtask

   int  rises[$];
   bit  prev_frame;
   int  fc0;
   int  dt0;
   bit  wrap_seen;
   int  guard;

   initial begin
      model_reset();

      // Reset, then ready rises on the first edge after release.
      do_reset(2);
      step(1'b0, '0, 1'b1);
      check("ready_after_reset", bus_m.in_ready, 1);

      // Plain frame 1010 with shift_en held.
      step(1'b1, 4'b1010, 1'b1);
      repeat (8) step(1'b0, '0, 1'b1);
      check("t2_frame_cnt", bus_m.frame_cnt, 1);

      // 1100 with a three-cycle stall after the second bit.
      fc0 = frame_cyc_m;
      dt0 = done_total;
      step(1'b1, 4'b1100, 1'b1);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);
      repeat (3) step(1'b0, '0, 1'b0);
      repeat (6) step(1'b0, '0, 1'b1);
      check("t3_frame_cycles", frame_cyc_m - fc0, 7);
      check("t3_done_count", done_total - dt0, 1);

      // Back-to-back words with in_valid held: frame starts 6 cycles apart.
      prev_frame = bus_m.s_frame;
      for (int c = 0; c < 16; c++) begin
         if (c < 6) step(1'b1, 4'b1111, 1'b1);
         else if (c < 8) step(1'b1, 4'b0110, 1'b1);
         else step(1'b0, '0, 1'b1);
         if (bus_m.s_frame && !prev_frame) rises.push_back(c);
         prev_frame = bus_m.s_frame;
      end
      check("t4_frames_seen", rises.size(), 2);
      if (rises.size() >= 2) check("t4_spacing", rises[1] - rises[0], 6);

      // Reset after two bits of 1011: no done, count stays 0.
      do_reset(1);
      step(1'b0, '0, 1'b1);
      dt0 = done_total;
      step(1'b1, 4'b1011, 1'b1);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);
      do_reset(2);
      step(1'b0, '0, 1'b1);
      check("t5_no_done", done_total - dt0, 0);
      check("t5_frame_cnt", bus_m.frame_cnt, 0);
      step(1'b1, 4'b0110, 1'b1);
      repeat (7) step(1'b0, '0, 1'b1);
      check("t5_next_frame", bus_m.frame_cnt, 1);

      // 0001 through both instances (LSB-first shows 1,0,0,0).
      step(1'b1, 4'b0001, 1'b1);
      repeat (7) step(1'b0, '0, 1'b1);

      // Random traffic without reset until frame_cnt has wrapped.
      wrap_seen = 1'b0;
      guard     = 0;
      while (done_cnt < 262 && guard < 6000) begin
         step($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 4) != 0);
         if (done_cnt == 256 && !wrap_seen) begin
            wrap_seen = 1'b1;
            check("t6_wrap", bus_m.frame_cnt, 0);
         end
         guard++;
      end
      check("t6_budget", guard < 6000, 1);
      check("t6_wrap_reached", wrap_seen, 1);

      // Random traffic with occasional resets landing anywhere in a frame.
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 59) == 0) do_reset($urandom_range(1, 2));
         else step($urandom_range(0, 2) != 0, W'($urandom), $urandom_range(0, 3) != 0);
      end

      // Drain and confirm every accepted word came out.
      repeat (20) step(1'b0, '0, 1'b1);
      check("drain_m", exp_m.size(), 0);
      check("drain_l", exp_l.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
